inst_queue: RTL
===============

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries; power of two, 2..32.
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, instruction word driven when output is invalid.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  discard all entries (redirect/mispredict).
REQ-006 SHALL have port in_valid  input  1  fetch offers an instruction.
REQ-007 SHALL have port in_ready  output  1  queue accepts the offer this cycle.
REQ-008 SHALL have port in_pc  input  32  PC of offered instruction.
REQ-009 SHALL have port in_inst  input  32  offered instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry presented to the decoder.
REQ-011 SHALL have port out_ready  input  1  decoder consumes the head this cycle.
REQ-012 SHALL have port out_pc  output  32  PC of head entry.
REQ-013 SHALL have port out_inst  output  32  head instruction word; feeds the decoder inst input.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL enqueue on a rising edge when in_valid && in_ready; SHALL dequeue when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !flush && (count < DEPTH); in_ready SHALL NOT depend on out_ready (full + simultaneous dequeue still refuses).
REQ-017 SHALL drive out_valid = !flush && (count != 0), except as in REQ-026.
REQ-018 SHALL drive out_inst = NOP_INST and out_pc = 0 whenever out_valid is 0.
REQ-019 SHALL read the head entry combinationally; an entry enqueued at edge N SHALL appear on out_* in the cycle after edge N (latency 1).
REQ-020 SHALL keep count unchanged on simultaneous enqueue and dequeue, including at count == 1.
REQ-021 SHALL preserve strict FIFO order; head and tail pointers SHALL wrap modulo DEPTH without a gap or bubble.
REQ-022 SHALL, on flush at an edge, set head = tail = 0, count = 0 and ignore any enqueue or dequeue presented that cycle; flush SHALL take priority over all other events.
REQ-023 SHALL leave count, pointers and storage unchanged when a handshake is not completed (in_valid with in_ready low, out_ready with out_valid low).
REQ-024 SHALL hold out_pc/out_inst stable while out_valid && !out_ready.

Reset
REQ-025 SHALL, while rst_n is low, force head = 0, tail = 0, count = 0, hence in_ready = 1 (if flush low), out_valid = 0, out_inst = NOP_INST, out_pc = 0; entry storage SHALL NOT be reset; reset deassertion mid-stream SHALL restart from empty.

Configuration
REQ-026 SHALL support macro INST_QUEUE_BYPASS_EN: when defined and count == 0 and !flush, out_valid = in_valid and out_pc/out_inst = in_pc/in_inst combinationally; if out_ready is also high the entry SHALL NOT be written and count SHALL stay 0; otherwise it SHALL be enqueued normally.
REQ-027 SHALL, without INST_QUEUE_BYPASS_EN, never present an input on out_* in the cycle it is offered (empty latency 1 per REQ-019).

Verification
REQ-028 SHALL cover: reset, then enqueue pc 0x100 inst 0x00500093, out_ready=0 -> next cycle out_valid=1, out_pc=0x100, out_inst=0x00500093, count=1.
REQ-029 SHALL cover: fill DEPTH=8 entries with out_ready=0 -> count=8, in_ready=0; 9th offer with out_ready=1 -> refused, count=7 next cycle.
REQ-030 SHALL cover: continuous enqueue/dequeue at full rate for 20 entries (pointer wrap twice) -> outputs in order pc 0x0,0x4,...,0x4C, count constant.
REQ-031 SHALL cover: count=5, flush=1 with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0 that cycle, count=0 next cycle, out_inst=0x00000013.
REQ-032 SHALL cover: rst_n low mid-stream at count=3 -> count=0 and out_valid=0 immediately, without a clock edge.
REQ-033 SHALL cover with INST_QUEUE_BYPASS_EN: empty, in_valid=1, out_ready=1, inst 0x00208133 -> out_inst=0x00208133 same cycle, count stays 0; without macro -> out_valid=0 that cycle, count=1 next.

Source files
------------

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : Fetch-to-decode instruction FIFO with combinational head read.
//            Optional INST_QUEUE_BYPASS_EN forwards the offer straight to
//            the decoder when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              c_AW      = $clog2(DEPTH);
   localparam logic [c_AW:0]   c_FULL    = DEPTH[c_AW:0];
   localparam logic [c_AW:0]   c_CNT_ONE = 1;
   localparam logic [c_AW-1:0] c_PTR_ONE = 1;

   logic [c_AW-1:0] r_head;
   logic [c_AW-1:0] r_tail;
   logic [c_AW:0]   r_count;
   logic [31:0]     r_pc_mem   [DEPTH];
   logic [31:0]     r_inst_mem [DEPTH];

   logic w_not_empty;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   assign w_not_empty = (r_count != '0);

`ifdef INST_QUEUE_BYPASS_EN
   assign w_bypass = !flush && !w_not_empty && in_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // in_ready deliberately ignores out_ready: a full queue refuses even when draining.
   assign in_ready = !flush && (r_count < c_FULL);
   // A bypassed instruction consumed in the same cycle never touches storage.
   assign w_push   = in_valid && in_ready && !(w_bypass && out_ready);
   assign w_pop    = out_ready && !flush && w_not_empty;
   assign count    = r_count;

   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_inst  = NOP_INST;
      if (w_bypass) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_inst  = in_inst;
      end else if (!flush && w_not_empty) begin
         out_valid = 1'b1;
         out_pc    = r_pc_mem[r_head];
         out_inst  = r_inst_mem[r_head];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + c_PTR_ONE;
         if (w_pop)  r_head <= r_head + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is intentionally left unreset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_tail]   <= in_pc;
         r_inst_mem[r_tail] <= in_inst;
      end
   end

endmodule
`default_nettype wire
